// File: rtl/decode_bpred_pkg.sv
// Shared types for the decode-stage branch predictor.
// The table entry struct lives in the top module because its width depends on module parameters.
package decode_bpred_pkg;

  typedef enum logic {
    BP_IDLE  = 1'b0,
    BP_SWEEP = 1'b1
  } bpred_state_t;

  localparam int unsigned BP_XLEN = 32;

endpackage

// File: rtl/decode_bpred_if.sv
// Fetch/decode-side bundle of the branch predictor.
// The master modport is the pipeline side; the slave modport is the predictor side.
interface decode_bpred_if #(
  parameter int PERF_W = 16
) ();
  logic              lookup_pc_dummy_unused;
  logic [31:0]       lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              update_en;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic [31:0]       update_target;
  logic              update_pred;
  logic [31:0]       update_ptarget;
  logic              inval_req;
  logic              busy;
  logic              mispredict;
  logic [PERF_W-1:0] mispredict_cnt;

  modport master (
    output lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred, update_ptarget, inval_req,
    input  pred_hit, pred_taken, pred_target, busy, mispredict, mispredict_cnt
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_taken, update_target,
           update_pred, update_ptarget, inval_req,
    output pred_hit, pred_taken, pred_target, busy, mispredict, mispredict_cnt
  );
endinterface

// File: rtl/decode_bpred_sat_counter.sv
// Combinational saturating increment/decrement of a W-bit value.
// Asserting both or neither of inc/dec leaves the value unchanged.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_val,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);

  always_comb begin
    o_val = i_val;
    if (i_inc && !i_dec) begin
      if (i_val != '1) o_val = i_val + W'(1);
    end else if (i_dec && !i_inc) begin
      if (i_val != '0) o_val = i_val - W'(1);
    end
  end

endmodule

// File: rtl/decode_bpred.sv
// Direct-mapped BTB with per-entry saturating direction counters, a sweep-invalidate FSM
// and a saturating mispredict counter. Lookup is combinational; training happens on CLK.
module decode_bpred
  import decode_bpred_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic           CLK,
  input  logic           RST,
  decode_bpred_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = BP_XLEN - 2 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [CNT_W-1:0] cnt;
  } bpred_entry_t;

  bpred_entry_t       r_tab [ENTRIES];
  bpred_state_t       r_state;
  bpred_state_t       w_next_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [PERF_W-1:0]  r_mis_cnt;
  logic [PERF_W-1:0]  w_mis_cnt_nxt;

  logic               w_busy;
  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  bpred_entry_t       w_lk;
  logic               w_lk_hit;

  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  bpred_entry_t       w_up;
  logic               w_up_hit;
  logic [CNT_W-1:0]   w_up_cnt_nxt;
  bpred_entry_t       w_alloc;
  logic               w_mis;

  assign w_busy = (r_state == BP_SWEEP);

  // Lookup path: no bypass of a same-cycle update, and masked while sweeping.
  assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
  assign w_lk_tag = bp.lookup_pc[31:IDX_W+2];
  assign w_lk     = r_tab[w_lk_idx];
  assign w_lk_hit = !w_busy && w_lk.valid && (w_lk.tag == w_lk_tag);

  assign bp.pred_hit    = w_lk_hit;
  assign bp.pred_taken  = w_lk_hit && w_lk.cnt[CNT_W-1];
  assign bp.pred_target = w_lk_hit ? w_lk.target : '0;

  assign w_up_idx = bp.update_pc[IDX_W+1:2];
  assign w_up_tag = bp.update_pc[31:IDX_W+2];
  assign w_up     = r_tab[w_up_idx];
  assign w_up_hit = w_up.valid && (w_up.tag == w_up_tag);

  sat_counter #(.W(CNT_W)) u_dir_cnt (
    .i_val (w_up.cnt),
    .i_inc (bp.update_taken),
    .i_dec (!bp.update_taken),
    .o_val (w_up_cnt_nxt)
  );

  always_comb begin
    w_alloc        = '0;
    w_alloc.valid  = 1'b1;
    w_alloc.tag    = w_up_tag;
    w_alloc.target = bp.update_target;
    w_alloc.cnt    = CNT_WEAK;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) r_tab[i] <= '0;
    end else if (w_busy) begin
      r_tab[r_ptr].valid <= 1'b0;
    end else if (bp.update_en) begin
      if (w_up_hit) begin
        r_tab[w_up_idx].cnt <= w_up_cnt_nxt;
        if (bp.update_taken) r_tab[w_up_idx].target <= bp.update_target;
      end else if (bp.update_taken) begin
        r_tab[w_up_idx] <= w_alloc;
      end
    end
  end

  // Mispredicts are counted even while busy drops the table update.
  assign w_mis = bp.update_en &&
                 ((bp.update_pred != bp.update_taken) ||
                  (bp.update_taken && (bp.update_ptarget != bp.update_target)));

  sat_counter #(.W(PERF_W)) u_perf_cnt (
    .i_val (r_mis_cnt),
    .i_inc (w_mis),
    .i_dec (1'b0),
    .o_val (w_mis_cnt_nxt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_mis_cnt <= '0;
    else     r_mis_cnt <= w_mis_cnt_nxt;
  end

  assign bp.busy           = w_busy;
  assign bp.mispredict     = w_mis;
  assign bp.mispredict_cnt = r_mis_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= BP_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      r_ptr   <= w_next_ptr;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    case (r_state)
      BP_IDLE: begin
        if (bp.inval_req) begin
          w_next_state = BP_SWEEP;
          w_next_ptr   = '0;
        end
      end
      BP_SWEEP: begin
        w_next_ptr = r_ptr + IDX_W'(1);
        if (r_ptr == IDX_W'(ENTRIES - 1)) begin
          w_next_state = BP_IDLE;
          w_next_ptr   = '0;
        end
      end
      default: begin
        w_next_state = BP_IDLE;
        w_next_ptr   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decode_bpred.sv
// Directed bench for decode_bpred (ENTRIES=16, CNT_W=2, PERF_W=2).
module tb_decode_bpred;

  logic CLK;
  logic RST;
  int   n_vec;
  int   n_err;
  int   busy_cycles;

  decode_bpred_if #(.PERF_W(2)) bif ();

  decode_bpred #(.ENTRIES(16), .CNT_W(2), .PERF_W(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bp  (bif)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic pr, input logic [31:0] ptgt);
    bif.update_en      = 1'b1;
    bif.update_pc      = pc;
    bif.update_taken   = tk;
    bif.update_target  = tgt;
    bif.update_pred    = pr;
    bif.update_ptarget = ptgt;
  endtask

  task automatic look(input logic [31:0] pc);
    bif.lookup_pc = pc;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    bif.lookup_pc = '0;
    bif.update_en = 1'b0;
    bif.update_pc = '0;
    bif.update_taken = 1'b0;
    bif.update_target = '0;
    bif.update_pred = 1'b0;
    bif.update_ptarget = '0;
    bif.inval_req = 1'b0;
    bif.lookup_pc_dummy_unused = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    look(32'h40);
    chk("rst_hit",    32'(bif.pred_hit),       0);
    chk("rst_taken",  32'(bif.pred_taken),     0);
    chk("rst_target", bif.pred_target,         0);
    chk("rst_busy",   32'(bif.busy),           0);
    chk("rst_mcnt",   32'(bif.mispredict_cnt), 0);

    // Allocate 0x40 taken -> weakly taken, mispredicted (pred was 0)
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    #1;
    chk("alloc_mis", 32'(bif.mispredict), 1);
    chk("same_cycle_nobypass", 32'(bif.pred_hit), 0);
    tick();
    bif.update_en = 1'b0;
    #1;
    chk("alloc_hit",    32'(bif.pred_hit),       1);
    chk("alloc_taken",  32'(bif.pred_taken),     1);
    chk("alloc_target", bif.pred_target,         32'h100);
    chk("alloc_mcnt",   32'(bif.mispredict_cnt), 1);

    // Three not-taken: cnt 2 -> 1 -> 0 -> 0
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("nt_nomis", 32'(bif.mispredict), 0);
    tick();
    chk("nt1_hit",   32'(bif.pred_hit),   1);
    chk("nt1_taken", 32'(bif.pred_taken), 0);
    tick();
    chk("nt2_hit",   32'(bif.pred_hit),   1);
    tick();
    chk("nt3_hit",   32'(bif.pred_hit),   1);
    chk("nt3_taken", 32'(bif.pred_taken), 0);
    // One taken from the floor: 0 -> 1, still predicts not-taken
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();
    chk("floor_taken", 32'(bif.pred_taken), 0);
    // 1 -> 2 -> 3 -> 3, then one not-taken -> 2 (still taken)
    tick();
    tick();
    tick();
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    bif.update_en = 1'b0;
    #1;
    chk("top_sat_taken", 32'(bif.pred_taken),     1);
    chk("top_sat_mcnt",  32'(bif.mispredict_cnt), 1);

    // Aliasing: 0x80 shares index 0 with 0x40
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    bif.update_en = 1'b0;
    look(32'h40);
    chk("alias_old_hit", 32'(bif.pred_hit), 0);
    look(32'h80);
    chk("alias_new_hit",    32'(bif.pred_hit),       1);
    chk("alias_new_target", bif.pred_target,         32'h200);
    chk("alias_new_taken",  32'(bif.pred_taken),     1);
    chk("alias_mcnt",       32'(bif.mispredict_cnt), 2);

    // Target-only mispredict on a hit entry
    upd(32'h44, 1'b1, 32'h300, 1'b1, 32'h300);
    #1;
    chk("tgt_ok_mis", 32'(bif.mispredict), 0);
    tick();
    upd(32'h44, 1'b1, 32'h304, 1'b1, 32'h300);
    #1;
    chk("tgt_bad_mis", 32'(bif.mispredict), 1);
    tick();
    bif.update_en = 1'b0;
    look(32'h44);
    chk("tgt_retrain", bif.pred_target,         32'h304);
    chk("tgt_mcnt",    32'(bif.mispredict_cnt), 3);

    // Sweep: inval_req held a few cycles into the sweep must not restart it
    bif.inval_req = 1'b1;
    tick();
    upd(32'h48, 1'b1, 32'h400, 1'b1, 32'h400);
    busy_cycles = 0;
    for (int c = 0; c < 40 && bif.busy; c++) begin
      busy_cycles++;
      chk("sweep_hit", 32'(bif.pred_hit), 0);
      if (c == 4) bif.inval_req = 1'b0;
      tick();
    end
    bif.update_en = 1'b0;
    bif.inval_req = 1'b0;
    chk("sweep_len", busy_cycles, 16);
    look(32'h44);
    chk("post_sweep_44", 32'(bif.pred_hit), 0);
    look(32'h80);
    chk("post_sweep_80", 32'(bif.pred_hit), 0);
    look(32'h48);
    chk("post_sweep_dropped_48", 32'(bif.pred_hit), 0);

    // Reset in the middle of a sweep
    upd(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();
    bif.update_en = 1'b0;
    look(32'h40);
    chk("pre_midrst_hit", 32'(bif.pred_hit), 1);
    bif.inval_req = 1'b1;
    tick();
    bif.inval_req = 1'b0;
    tick();
    tick();
    chk("midrst_busy_before", 32'(bif.busy), 1);
    RST = 1'b1;
    #1;
    chk("midrst_busy", 32'(bif.busy),           0);
    chk("midrst_mcnt", 32'(bif.mispredict_cnt), 0);
    tick();
    RST = 1'b0;
    look(32'h40);
    chk("midrst_hit", 32'(bif.pred_hit), 0);
    tick();
    chk("midrst_busy_after", 32'(bif.busy), 0);

    // PERF_W=2 saturation: 1,2,3,3
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("perf_sat", 32'(bif.mispredict_cnt), (i < 3) ? (i + 1) : 3);
    end
    bif.update_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
